// File: rtl/shell_pool_if.sv
// rtl/shell_pool_if.sv - wall-map query bus between the shell pool and the wall map
interface shell_pool_if;
    logic [5:0] o_query_x;
    logic [5:0] o_query_y;
    logic       i_query_wall;

    // pool side: presents an address, receives the wall flag one cycle later
    modport master (
        output o_query_x,
        output o_query_y,
        input  i_query_wall
    );

    // wall-map side
    modport slave (
        input  o_query_x,
        input  o_query_y,
        output i_query_wall
    );
endinterface

// File: rtl/shell_pool.sv
// rtl/shell_pool.sv - per-tank shell slots: spawn on fire, advance on step, wall/edge kill
module shell_pool #(
    parameter int NUM_SHELL   = 5,
    parameter int GAME_WIDTH  = 64,
    parameter int GAME_HEIGHT = 44
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             i_state,
    input  logic                   i_vga_buzy,
    input  logic                   i_fire,
    input  logic                   i_step,
    input  logic [5:0]             i_tank_x,
    input  logic [5:0]             i_tank_y,
    input  logic [1:0]             i_tank_dir,
    shell_pool_if.master           query_if,
    output logic [6*NUM_SHELL-1:0] o_shell_x,
    output logic [6*NUM_SHELL-1:0] o_shell_y,
    output logic [NUM_SHELL-1:0]   o_shell_valid,
    output logic [2:0]             o_remain,
    output logic                   o_busy
);
    localparam int         IW   = (NUM_SHELL > 1) ? $clog2(NUM_SHELL) : 1;
    localparam logic [5:0] XMAX = 6'(GAME_WIDTH - 1);
    localparam logic [5:0] YMAX = 6'(GAME_HEIGHT - 1);
    localparam logic [1:0] PLAYING = 2'b01;

    typedef enum logic [2:0] {IDLE, FIRE_Q, FIRE_CHK, STEP_Q, STEP_CHK} state_t;

    // One cell in direction d; bit 12 flags leaving the playfield, [11:6] x, [5:0] y.
    function automatic logic [12:0] next_cell(input logic [5:0] x, input logic [5:0] y,
                                              input logic [1:0] d);
        logic       oob;
        logic [5:0] nx;
        logic [5:0] ny;
        oob = 1'b0;
        nx  = x;
        ny  = y;
        case (d)
            2'd0:    begin oob = (y == 6'd0); ny = y - 6'd1; end
            2'd1:    begin oob = (x == XMAX); nx = x + 6'd1; end
            2'd2:    begin oob = (y == YMAX); ny = y + 6'd1; end
            default: begin oob = (x == 6'd0); nx = x - 6'd1; end
        endcase
        return {oob, nx, ny};
    endfunction

    state_t               r_st;
    logic [5:0]           r_x   [NUM_SHELL];
    logic [5:0]           r_y   [NUM_SHELL];
    logic [1:0]           r_dir [NUM_SHELL];
    logic [NUM_SHELL-1:0] r_valid;
    logic [2:0]           r_remain;
    logic                 r_fire_pend;
    logic                 r_step_pend;
    logic [IW-1:0]        r_idx;
    logic [5:0]           r_qx;
    logic [5:0]           r_qy;
    logic [5:0]           r_sp_x;
    logic [5:0]           r_sp_y;
    logic [1:0]           r_sp_dir;
    logic                 r_sp_oob;

    logic                 w_playing;
    logic                 w_go_fire;
    logic                 w_go_step;
    logic [12:0]          w_spawn;
    logic [5:0]           w_cur_x;
    logic [5:0]           w_cur_y;
    logic [1:0]           w_cur_d;
    logic                 w_cur_v;
    logic [12:0]          w_cur_nc;
    logic [IW-1:0]        w_nq_idx;
    logic [5:0]           w_nq_x;
    logic [5:0]           w_nq_y;
    logic [1:0]           w_nq_d;
    logic                 w_nq_v;
    logic [12:0]          w_nq_nc;
    logic                 w_nq_live;
    logic                 w_free_any;
    logic [IW-1:0]        w_free_idx;
    logic [NUM_SHELL-1:0] w_valid_nxt;
    logic [2:0]           w_remain_nxt;

    assign w_playing = (i_state == PLAYING);
    // Fire wins over step when both are pending at departure.
    assign w_go_fire = (r_st == IDLE) && w_playing && !i_vga_buzy && r_fire_pend;
    assign w_go_step = (r_st == IDLE) && w_playing && !i_vga_buzy && !r_fire_pend && r_step_pend;
    assign w_spawn   = next_cell(i_tank_x, i_tank_y, i_tank_dir);

    // Slot under check (r_idx) and slot whose query is loaded next (0 from IDLE, else r_idx+1).
    always_comb begin
        w_cur_x  = '0;
        w_cur_y  = '0;
        w_cur_d  = '0;
        w_cur_v  = 1'b0;
        w_nq_x   = '0;
        w_nq_y   = '0;
        w_nq_d   = '0;
        w_nq_v   = 1'b0;
        w_nq_idx = (r_st == IDLE) ? '0 : r_idx + IW'(1);
        for (int k = 0; k < NUM_SHELL; k++) begin
            if (IW'(k) == r_idx) begin
                w_cur_x = r_x[k];
                w_cur_y = r_y[k];
                w_cur_d = r_dir[k];
                w_cur_v = r_valid[k];
            end
            if (IW'(k) == w_nq_idx) begin
                w_nq_x = r_x[k];
                w_nq_y = r_y[k];
                w_nq_d = r_dir[k];
                w_nq_v = r_valid[k];
            end
        end
    end

    assign w_cur_nc  = next_cell(w_cur_x, w_cur_y, w_cur_d);
    assign w_nq_nc   = next_cell(w_nq_x, w_nq_y, w_nq_d);
    assign w_nq_live = w_nq_v && !w_nq_nc[12];

    // Lowest-index free slot.
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int k = NUM_SHELL - 1; k >= 0; k--) begin
            if (!r_valid[k]) begin
                w_free_any = 1'b1;
                w_free_idx = IW'(k);
            end
        end
    end

    // Next valid vector and its free count, so o_remain tracks valid in the same cycle.
    always_comb begin
        w_valid_nxt  = r_valid;
        w_remain_nxt = 3'(NUM_SHELL);
        if (!w_playing) begin
            w_valid_nxt = '0;
        end else if (r_st == FIRE_CHK && !query_if.i_query_wall && w_free_any) begin
            for (int k = 0; k < NUM_SHELL; k++)
                if (IW'(k) == w_free_idx) w_valid_nxt[k] = 1'b1;
        end else if (r_st == STEP_CHK && w_cur_v && (w_cur_nc[12] || query_if.i_query_wall)) begin
            for (int k = 0; k < NUM_SHELL; k++)
                if (IW'(k) == r_idx) w_valid_nxt[k] = 1'b0;
        end
        for (int k = 0; k < NUM_SHELL; k++)
            if (w_valid_nxt[k]) w_remain_nxt = w_remain_nxt - 3'd1;
    end

    // Valid bits and free-slot count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= '0;
            r_remain <= 3'(NUM_SHELL);
        end else begin
            r_valid  <= w_valid_nxt;
            r_remain <= w_remain_nxt;
        end
    end

    // Control FSM: pending flags, spawn capture, query address, slot coordinate updates.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st        <= IDLE;
            r_fire_pend <= 1'b0;
            r_step_pend <= 1'b0;
            r_idx       <= '0;
            r_qx        <= '0;
            r_qy        <= '0;
            r_sp_x      <= '0;
            r_sp_y      <= '0;
            r_sp_dir    <= '0;
            r_sp_oob    <= 1'b0;
            for (int k = 0; k < NUM_SHELL; k++) begin
                r_x[k]   <= '0;
                r_y[k]   <= '0;
                r_dir[k] <= '0;
            end
        end else if (!w_playing) begin
            r_st        <= IDLE;
            r_fire_pend <= 1'b0;
            r_step_pend <= 1'b0;
            r_idx       <= '0;
            r_qx        <= '0;
            r_qy        <= '0;
        end else begin
            r_fire_pend <= (r_fire_pend & ~w_go_fire) | i_fire;
            r_step_pend <= (r_step_pend & ~w_go_step) | i_step;
            case (r_st)
                IDLE: begin
                    r_qx <= '0;
                    r_qy <= '0;
                    if (w_go_fire) begin
                        r_st     <= FIRE_Q;
                        r_sp_x   <= w_spawn[11:6];
                        r_sp_y   <= w_spawn[5:0];
                        r_sp_dir <= i_tank_dir;
                        r_sp_oob <= w_spawn[12];
                        if (!w_spawn[12]) begin
                            r_qx <= w_spawn[11:6];
                            r_qy <= w_spawn[5:0];
                        end
                    end else if (w_go_step) begin
                        r_st  <= STEP_Q;
                        r_idx <= '0;
                        r_qx  <= w_nq_live ? w_nq_nc[11:6] : 6'd0;
                        r_qy  <= w_nq_live ? w_nq_nc[5:0]  : 6'd0;
                    end
                end
                FIRE_Q: begin
                    if (r_sp_oob) begin
                        r_st <= IDLE;
                        r_qx <= '0;
                        r_qy <= '0;
                    end else begin
                        r_st <= FIRE_CHK;
                    end
                end
                FIRE_CHK: begin
                    if (!query_if.i_query_wall && w_free_any) begin
                        for (int k = 0; k < NUM_SHELL; k++) begin
                            if (IW'(k) == w_free_idx) begin
                                r_x[k]   <= r_sp_x;
                                r_y[k]   <= r_sp_y;
                                r_dir[k] <= r_sp_dir;
                            end
                        end
                    end
                    r_st <= IDLE;
                    r_qx <= '0;
                    r_qy <= '0;
                end
                STEP_Q: begin
                    r_st <= STEP_CHK;
                end
                default: begin
                    if (w_cur_v && !w_cur_nc[12] && !query_if.i_query_wall) begin
                        for (int k = 0; k < NUM_SHELL; k++) begin
                            if (IW'(k) == r_idx) begin
                                r_x[k] <= w_cur_nc[11:6];
                                r_y[k] <= w_cur_nc[5:0];
                            end
                        end
                    end
                    if (r_idx == IW'(NUM_SHELL - 1)) begin
                        r_st <= IDLE;
                        r_qx <= '0;
                        r_qy <= '0;
                    end else begin
                        r_st  <= STEP_Q;
                        r_idx <= r_idx + IW'(1);
                        r_qx  <= w_nq_live ? w_nq_nc[11:6] : 6'd0;
                        r_qy  <= w_nq_live ? w_nq_nc[5:0]  : 6'd0;
                    end
                end
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_SHELL; g++) begin : g_pack
            assign o_shell_x[6*g +: 6] = r_x[g];
            assign o_shell_y[6*g +: 6] = r_y[g];
        end
    endgenerate

    assign o_shell_valid      = r_valid;
    assign o_remain           = r_remain;
    assign o_busy             = (r_st != IDLE);
    assign query_if.o_query_x = r_qx;
    assign query_if.o_query_y = r_qy;
endmodule

// File: tb/tb_shell_pool.sv
// tb/tb_shell_pool.sv - scoreboard bench for shell_pool
module tb_shell_pool;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  i_state;
    logic        i_vga_buzy;
    logic        i_fire;
    logic        i_step;
    logic [5:0]  i_tank_x;
    logic [5:0]  i_tank_y;
    logic [1:0]  i_tank_dir;
    logic [29:0] o_shell_x;
    logic [29:0] o_shell_y;
    logic [4:0]  o_shell_valid;
    logic [2:0]  o_remain;
    logic        o_busy;

    shell_pool_if bus ();

    shell_pool dut (
        .clk          (clk),
        .rst          (rst),
        .i_state      (i_state),
        .i_vga_buzy   (i_vga_buzy),
        .i_fire       (i_fire),
        .i_step       (i_step),
        .i_tank_x     (i_tank_x),
        .i_tank_y     (i_tank_y),
        .i_tank_dir   (i_tank_dir),
        .query_if     (bus.master),
        .o_shell_x    (o_shell_x),
        .o_shell_y    (o_shell_y),
        .o_shell_valid(o_shell_valid),
        .o_remain     (o_remain),
        .o_busy       (o_busy)
    );

    typedef struct {
        string      name;
        logic [4:0] v;
        logic [2:0] rem;
        int         slot;
        logic [5:0] x;
        logic [5:0] y;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_busy = 1'b0;
    logic wall_en = 1'b0;
    logic [5:0] wall_x = '0;
    logic [5:0] wall_y = '0;

    initial forever #5 clk = ~clk;

    // Wall map: a single optional wall cell, answered for the currently presented address.
    initial begin
        bus.i_query_wall = 1'b0;
        forever begin
            @(negedge clk);
            bus.i_query_wall = wall_en && (bus.o_query_x == wall_x) && (bus.o_query_y == wall_y);
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic [4:0] v, input logic [2:0] rem,
                        input int s, input logic [5:0] x, input logic [5:0] y);
        exp_t e;
        e.name = nm; e.v = v; e.rem = rem; e.slot = s; e.x = x; e.y = y;
        exp_q.push_back(e);
    endtask

    // Monitor: every completed operation (busy falling) retires one expected snapshot.
    always @(negedge clk) begin
        if (prev_busy && !o_busy) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got completion want none");
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, ".valid"}, int'(o_shell_valid), int'(mon_e.v));
                check({mon_e.name, ".remain"}, int'(o_remain), int'(mon_e.rem));
                check({mon_e.name, ".x"}, int'(o_shell_x[6*mon_e.slot +: 6]), int'(mon_e.x));
                check({mon_e.name, ".y"}, int'(o_shell_y[6*mon_e.slot +: 6]), int'(mon_e.y));
            end
        end
        prev_busy <= o_busy;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (o_busy) ok = 1'b1;
        end
        if (!ok) check("start_timeout", 0, 1);
    endtask

    task automatic wait_done(output int cycles);
        cycles = 1;
        while (o_busy && cycles < 50) begin
            @(negedge clk);
            if (o_busy) cycles++;
        end
        if (o_busy) check("done_timeout", 0, 1);
    endtask

    task automatic do_fire(input logic [5:0] tx, input logic [5:0] ty, input logic [1:0] td,
                           input bit chk_q, input logic [5:0] qx, input logic [5:0] qy);
        bit ok;
        int c;
        i_tank_x = tx; i_tank_y = ty; i_tank_dir = td;
        i_fire = 1'b1;
        tick(1);
        i_fire = 1'b0;
        wait_start(ok);
        if (ok) begin
            if (chk_q) begin
                check("fire_query_x", int'(bus.o_query_x), int'(qx));
                check("fire_query_y", int'(bus.o_query_y), int'(qy));
            end
            wait_done(c);
        end
        tick(1);
    endtask

    task automatic do_step(input bit chk_len);
        bit ok;
        int c;
        i_step = 1'b1;
        tick(1);
        i_step = 1'b0;
        wait_start(ok);
        if (ok) begin
            wait_done(c);
            if (chk_len) check("sweep_cycles", c, 10);
        end
        tick(1);
    endtask

    initial begin
        bit ok;
        int c;
        int busy_seen;
        rst = 1'b1; i_state = 2'b01; i_vga_buzy = 1'b0; i_fire = 1'b0; i_step = 1'b0;
        i_tank_x = '0; i_tank_y = '0; i_tank_dir = '0;
        tick(2);
        check("rst_valid", int'(o_shell_valid), 0);
        check("rst_remain", int'(o_remain), 5);
        check("rst_busy", int'(o_busy), 0);
        check("rst_query_x", int'(bus.o_query_x), 0);
        check("rst_shell_x", int'(o_shell_x), 0);
        rst = 1'b0;
        tick(2);

        // Fill the pool from tank (10,10) facing right; sixth fire is dropped.
        push("fire1", 5'b00001, 3'd4, 0, 6'd11, 6'd10);
        do_fire(6'd10, 6'd10, 2'd1, 1'b1, 6'd11, 6'd10);
        push("fire2", 5'b00011, 3'd3, 1, 6'd11, 6'd10);
        do_fire(6'd10, 6'd10, 2'd1, 1'b0, 6'd0, 6'd0);
        push("fire3", 5'b00111, 3'd2, 2, 6'd11, 6'd10);
        do_fire(6'd10, 6'd10, 2'd1, 1'b0, 6'd0, 6'd0);
        push("fire4", 5'b01111, 3'd1, 3, 6'd11, 6'd10);
        do_fire(6'd10, 6'd10, 2'd1, 1'b0, 6'd0, 6'd0);
        push("fire5", 5'b11111, 3'd0, 4, 6'd11, 6'd10);
        do_fire(6'd10, 6'd10, 2'd1, 1'b0, 6'd0, 6'd0);
        push("fire6_drop", 5'b11111, 3'd0, 4, 6'd11, 6'd10);
        do_fire(6'd10, 6'd10, 2'd1, 1'b0, 6'd0, 6'd0);

        // One full sweep moves every shell right.
        push("sweep_all", 5'b11111, 3'd0, 2, 6'd12, 6'd10);
        do_step(1'b1);

        // Leave playing mid-sweep: everything drops on the next edge, slot 4 untouched.
        push("abort_state", 5'b00000, 3'd5, 4, 6'd12, 6'd10);
        i_step = 1'b1;
        tick(1);
        i_step = 1'b0;
        wait_start(ok);
        tick(3);
        i_state = 2'b00;
        tick(1);
        check("abort_busy", int'(o_busy), 0);
        check("abort_remain", int'(o_remain), 5);
        i_state = 2'b01;
        tick(2);

        // Right edge: (62,5) -> (63,5) -> killed, coordinates kept.
        push("edge_fire", 5'b00001, 3'd4, 0, 6'd62, 6'd5);
        do_fire(6'd61, 6'd5, 2'd1, 1'b1, 6'd62, 6'd5);
        push("edge_step1", 5'b00001, 3'd4, 0, 6'd63, 6'd5);
        do_step(1'b1);
        push("edge_step2", 5'b00000, 3'd5, 0, 6'd63, 6'd5);
        do_step(1'b1);

        // Wall ahead at (20,19) kills a shell at (20,20) heading up.
        push("wall_fire", 5'b00001, 3'd4, 0, 6'd20, 6'd20);
        do_fire(6'd20, 6'd21, 2'd0, 1'b1, 6'd20, 6'd20);
        wall_en = 1'b1; wall_x = 6'd20; wall_y = 6'd19;
        push("wall_step", 5'b00000, 3'd5, 0, 6'd20, 6'd20);
        do_step(1'b1);

        // Fire straight into a wall: no allocation.
        wall_x = 6'd30; wall_y = 6'd31;
        push("fire_into_wall", 5'b00000, 3'd5, 0, 6'd20, 6'd20);
        do_fire(6'd30, 6'd30, 2'd2, 1'b1, 6'd30, 6'd31);
        wall_en = 1'b0;

        // Spawn off the left edge: no allocation.
        push("fire_oob", 5'b00000, 3'd5, 0, 6'd20, 6'd20);
        do_fire(6'd0, 6'd7, 2'd3, 1'b0, 6'd0, 6'd0);

        // Steps while the display is busy merge into a single sweep once it idles.
        push("buzy_fire", 5'b00001, 3'd4, 0, 6'd40, 6'd39);
        do_fire(6'd40, 6'd40, 2'd0, 1'b0, 6'd0, 6'd0);
        i_vga_buzy = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 3; i++) begin
            i_step = 1'b1;
            tick(1);
            i_step = 1'b0;
            tick(1);
            if (o_busy) busy_seen++;
        end
        tick(5);
        if (o_busy) busy_seen++;
        check("buzy_hold_busy", busy_seen, 0);
        check("buzy_hold_y", int'(o_shell_y[5:0]), 39);
        push("buzy_sweep", 5'b00001, 3'd4, 0, 6'd40, 6'd38);
        i_vga_buzy = 1'b0;
        wait_start(ok);
        if (ok) begin
            wait_done(c);
            check("buzy_sweep_cycles", c, 10);
        end
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (o_busy) busy_seen++;
        end
        check("single_sweep", busy_seen, 0);

        // Asynchronous reset mid-sweep: no partial commit, all state cleared.
        push("rst_abort", 5'b00000, 3'd5, 0, 6'd0, 6'd0);
        i_step = 1'b1;
        tick(1);
        i_step = 1'b0;
        wait_start(ok);
        tick(1);
        #2 rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/shell_pool.md
SHELL_POOL -- requirements
Module: shell_pool

Interface
REQ-001 Parameter NUM_SHELL, default 5, number of shell slots owned by one tank.
REQ-002 Parameter GAME_WIDTH, default 64, playfield width in grid cells.
REQ-003 Parameter GAME_HEIGHT, default 44, playfield height in grid cells.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 i_state  in  2  game state; 2'b01 = playing, any other value = not playing.
REQ-007 i_vga_buzy  in  1  high while the display scans the active region.
REQ-008 i_fire  in  1  single-cycle fire pulse from the tank controller.
REQ-009 i_step  in  1  single-cycle shell-advance tick.
REQ-010 i_tank_x / i_tank_y / i_tank_dir  in  6/6/2  owning tank position and heading (0 up, 1 right, 2 down, 3 left).
REQ-011 o_query_x / o_query_y  out  6/6  wall-map lookup address.
REQ-012 i_query_wall  in  1  wall flag for the address presented on the previous cycle.
REQ-013 o_shell_x / o_shell_y  out  6*NUM_SHELL  packed slot coordinates; slot k at bits [6k+5:6k].
REQ-014 o_shell_valid  out  NUM_SHELL  per-slot live flag.
REQ-015 o_remain  out  3  count of free slots.
REQ-016 o_busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 FSM states: IDLE, FIRE_Q, FIRE_CHK, STEP_Q, STEP_CHK.
REQ-018 i_fire and i_step each set a sticky pending flag; repeat pulses while pending merge into one.
REQ-019 Leaving IDLE requires i_vga_buzy low and i_state == 2'b01.
REQ-020 Departure from IDLE: pending fire goes to FIRE_Q before pending step goes to STEP_Q; the chosen flag clears on departure.
REQ-021 Spawn cell = tank cell plus one cell in i_tank_dir, sampled in the cycle IDLE is left.
REQ-022 Out-of-bounds spawn cell (x-1 at 0, x+1 at GAME_WIDTH-1, y-1 at 0, y+1 at GAME_HEIGHT-1): FSM returns to IDLE with no allocation.
REQ-023 In-bounds spawn cell: FIRE_Q drives the spawn cell on o_query_*; FIRE_CHK follows.
REQ-024 In FIRE_CHK: if i_query_wall is 0 and a slot is free, the lowest-index free slot is loaded with the spawn cell and heading and set valid; otherwise nothing changes; then IDLE.
REQ-025 Step sweep visits slots 0..NUM_SHELL-1 in order, each for exactly one STEP_Q and one STEP_CHK cycle; sweep length is 2*NUM_SHELL cycles, then IDLE.
REQ-026 STEP_Q for a valid slot drives its next cell on o_query_*.
REQ-027 STEP_CHK for a valid slot whose next cell is out of bounds clears valid and ignores i_query_wall.
REQ-028 STEP_CHK for a valid slot with in-bounds next cell: i_query_wall = 1 clears valid; otherwise the slot moves to the next cell.
REQ-029 Invalid slots are visited in the sweep but never modified.
REQ-030 A started fire or sweep runs to completion even if i_vga_buzy rises.
REQ-031 While i_state != 2'b01: all valid bits, both pending flags and the FSM return to IDLE/zero on the next edge, overriding any operation in progress.
REQ-032 Cleared slots keep their last coordinates; only valid is cleared.
REQ-033 o_remain = NUM_SHELL minus popcount(o_shell_valid), registered in the same cycle as the valid bits.
REQ-034 In IDLE, o_query_x/o_query_y hold 0.

Reset
REQ-035 While rst is high: all slot coordinates, headings and valid bits are 0; pending flags are 0; FSM is IDLE; o_query_* are 0; o_remain = NUM_SHELL; o_busy = 0.
REQ-036 Reset asserted mid-sweep aborts the sweep immediately with no partial commit.

Verification
REQ-037 Tank (10,10) dir 1, i_fire, i_vga_buzy=0, wall=0 -> slot0 valid at (11,10) two cycles after leaving IDLE; o_remain = 4.
REQ-038 Six fires with no walls -> slots 0..4 valid, sixth fire drops, o_remain = 0.
REQ-039 Shell at (62,5) heading right, two steps -> (63,5) after the first step, valid cleared after the second; o_query never shows x = 64.
REQ-040 Shell at (20,20) heading up with i_query_wall = 1 for (20,19) -> valid cleared after the step; slot stays at (20,20).
REQ-041 i_step while i_vga_buzy=1 -> no movement until buzy falls, then exactly one 10-cycle sweep; three steps during buzy still give one sweep.
REQ-042 i_state forced to 2'b00 mid-sweep -> all valid 0, o_busy 0, o_remain 5 on the next edge.
